// File: rtl/disp_cmd_decoder.sv
// rtl/disp_cmd_decoder.sv - display command byte-stream decoder producing text-RAM writes
//
// Purpose: parses command/payload bytes from the host display-command FIFO
// into character/attribute RAM write requests. It keeps a cursor address and
// a current attribute.
//
// Ports:
//   clk            in  1       system clock
//   nrst           in  1       asynchronous active-low reset
//   disp_cmd       in  8       command/payload byte, qualified by disp_cmd_valid
//   disp_cmd_valid in  1       one byte per high cycle
//   mem_we         out 1       one-cycle text RAM write strobe
//   mem_addr       out ADDR_W  write address (holds when mem_we=0)
//   mem_wdata      out 16      {attr, char} (holds when mem_we=0)
//   cur_attr       out 8       current attribute
//   bad_cmd        out 1       sticky: unknown opcode or out-of-range address
//   idle           out 1       no command in progress
module disp_cmd_decoder #(
  parameter int         ADDR_W    = 12,
  parameter int         MEM_DEPTH = 3700,
  parameter logic [7:0] ATTR_RST  = 8'h0F
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        disp_cmd,
  input  logic              disp_cmd_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [7:0]        cur_attr,
  output logic              bad_cmd,
  output logic              idle
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_COUNT,
    S_DATA,
    S_ATTR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cursor;
  logic [7:0]        addr_lo;
  logic [8:0]        count;     // 9 bits so that N=0 can mean 256
  logic [15:0]       addr_full;

  // Full 16-bit SET_ADDR value, range-checked before truncation to ADDR_W.
  assign addr_full = {disp_cmd, addr_lo};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_OPCODE;
      idle      <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cursor    <= '0;
      addr_lo   <= '0;
      count     <= '0;
      cur_attr  <= ATTR_RST;
      bad_cmd   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (disp_cmd_valid) begin
        case (state)
          S_OPCODE: begin
            case (disp_cmd)
              8'h00: ;
              8'h01: begin state <= S_ADDR_LO; idle <= 1'b0; end
              8'h02: begin state <= S_COUNT;   idle <= 1'b0; end
              8'h03: begin state <= S_ATTR;    idle <= 1'b0; end
              default: bad_cmd <= 1'b1;
            endcase
          end
          S_ADDR_LO: begin
            addr_lo <= disp_cmd;
            state   <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            if (addr_full >= 16'(MEM_DEPTH)) begin
              cursor  <= '0;
              bad_cmd <= 1'b1;
            end else begin
              cursor <= addr_full[ADDR_W-1:0];
            end
            state <= S_OPCODE;
            idle  <= 1'b1;
          end
          S_COUNT: begin
            count <= (disp_cmd == 8'h00) ? 9'd256 : {1'b0, disp_cmd};
            state <= S_DATA;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= cursor;
            mem_wdata <= {cur_attr, disp_cmd};
            // Wrap check is done on the current value, before adding.
            if (cursor == ADDR_W'(MEM_DEPTH - 1))
              cursor <= '0;
            else
              cursor <= cursor + ADDR_W'(1);
            count <= count - 9'd1;
            if (count == 9'd1) begin
              state <= S_OPCODE;
              idle  <= 1'b1;
            end
          end
          S_ATTR: begin
            cur_attr <= disp_cmd;
            state    <= S_OPCODE;
            idle     <= 1'b1;
          end
          default: begin
            state <= S_OPCODE;
            idle  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_cmd_decoder.sv
// tb/tb_disp_cmd_decoder.sv - self-checking bench for disp_cmd_decoder
module tb_disp_cmd_decoder;

  logic        clk;
  logic        nrst;
  logic [7:0]  disp_cmd;
  logic        disp_cmd_valid;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  cur_attr;
  logic        bad_cmd;
  logic        idle;

  int n_checks = 0;
  int n_pass   = 0;

  logic [27:0] wq[$];

  disp_cmd_decoder dut (
    .clk            (clk),
    .nrst           (nrst),
    .disp_cmd       (disp_cmd),
    .disp_cmd_valid (disp_cmd_valid),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .cur_attr       (cur_attr),
    .bad_cmd        (bad_cmd),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk)
    if (nrst === 1'b1 && mem_we === 1'b1)
      wq.push_back({mem_addr, mem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock edge; returns 1 time unit after it.
  task automatic send(input logic [7:0] b);
    disp_cmd       = b;
    disp_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    disp_cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    disp_cmd = 8'h00;
    disp_cmd_valid = 1'b0;
    nrst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({mem_we, cur_attr, bad_cmd, idle, mem_addr, mem_wdata} !== {1'b0, 8'h0F, 1'b0, 1'b1, 12'h000, 16'h0000})
      $display("FAIL reset_state: we=%b attr=%h bad=%b idle=%b addr=%h wdata=%h, want 0 0F 0 1 000 0000",
               mem_we, cur_attr, bad_cmd, idle, mem_addr, mem_wdata);
    else n_pass++;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    wq.delete();
    send(8'h01); send(8'h10); send(8'h00);
    send(8'h02); send(8'h03);
    n_checks++;
    if (mem_we !== 1'b0) $display("FAIL basic_no_early_we: we=%b want 0", mem_we);
    else n_pass++;
    send(8'h41);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h010, 16'h0F41})
      $display("FAIL basic_w0_latency: we=%b addr=%h wdata=%h want 1 010 0F41", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    send(8'h42);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h011, 16'h0F42})
      $display("FAIL basic_w1: we=%b addr=%h wdata=%h want 1 011 0F42", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    send(8'h43);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, idle} !== {1'b1, 12'h012, 16'h0F43, 1'b1})
      $display("FAIL basic_w2: we=%b addr=%h wdata=%h idle=%b want 1 012 0F43 1", mem_we, mem_addr, mem_wdata, idle);
    else n_pass++;
    tick();
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, wq.size()} !== {1'b0, 12'h012, 16'h0F43, 32'd3})
      $display("FAIL basic_after: we=%b addr=%h wdata=%h writes=%0d want 0 012 0F43 3", mem_we, mem_addr, mem_wdata, wq.size());
    else n_pass++;
  endtask

  task automatic test_set_attr();
    wq.delete();
    send(8'h03); send(8'h1E);
    send(8'h02); send(8'h01); send(8'h58);
    tick();
    n_checks++;
    if (cur_attr !== 8'h1E) $display("FAIL attr_reg: got %h want 1E", cur_attr);
    else n_pass++;
    n_checks++;
    if (wq.size() != 1 || wq[0] !== {12'h013, 16'h1E58})
      $display("FAIL attr_write: count=%0d first=%h want 1 0131E58", wq.size(), (wq.size() > 0) ? wq[0] : 28'h0);
    else n_pass++;
  endtask

  task automatic test_wrap_and_range();
    wq.delete();
    send(8'h01); send(8'h73); send(8'h0E);
    n_checks++;
    if (bad_cmd !== 1'b0) $display("FAIL addr_3699_ok: bad=%b want 0", bad_cmd);
    else n_pass++;
    send(8'h02); send(8'h02); send(8'h61); send(8'h62);
    tick();
    n_checks++;
    if (wq.size() != 2 || wq[0] !== {12'd3699, 16'h1E61} || wq[1] !== {12'd0, 16'h1E62})
      $display("FAIL wrap_writes: count=%0d w0=%h w1=%h want 2 E731E61 0001E62", wq.size(),
               (wq.size() > 0) ? wq[0] : 28'h0, (wq.size() > 1) ? wq[1] : 28'h0);
    else n_pass++;
    send(8'h01); send(8'hA0); send(8'h0F);
    n_checks++;
    if ({bad_cmd, idle} !== 2'b11) $display("FAIL addr_4000_bad: bad=%b idle=%b want 1 1", bad_cmd, idle);
    else n_pass++;
    wq.delete();
    send(8'h02); send(8'h01); send(8'h63);
    tick();
    n_checks++;
    if (wq.size() != 1 || wq[0] !== {12'h000, 16'h1E63})
      $display("FAIL addr_4000_cursor: count=%0d w0=%h want 1 0001E63", wq.size(), (wq.size() > 0) ? wq[0] : 28'h0);
    else n_pass++;
  endtask

  task automatic test_bad_opcode();
    apply_reset();
    n_checks++;
    if (bad_cmd !== 1'b0) $display("FAIL bad_cleared_by_reset: bad=%b want 0", bad_cmd);
    else n_pass++;
    wq.delete();
    send(8'h7F);
    tick();
    n_checks++;
    if ({bad_cmd, idle, mem_we, wq.size()} !== {1'b1, 1'b1, 1'b0, 32'd0})
      $display("FAIL bad_opcode: bad=%b idle=%b we=%b writes=%0d want 1 1 0 0", bad_cmd, idle, mem_we, wq.size());
    else n_pass++;
    send(8'h00);
    tick();
    n_checks++;
    if ({bad_cmd, idle} !== 2'b11) $display("FAIL nop_after_bad: bad=%b idle=%b want 1 1", bad_cmd, idle);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cmd();
    send(8'h03); send(8'h55);
    send(8'h02); send(8'h05); send(8'h41); send(8'h42);
    #1;
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, cur_attr, bad_cmd, idle} !== {1'b0, 12'h000, 16'h0000, 8'h0F, 1'b0, 1'b1})
      $display("FAIL mid_reset_outputs: we=%b addr=%h wdata=%h attr=%h bad=%b idle=%b want 0 000 0000 0F 0 1",
               mem_we, mem_addr, mem_wdata, cur_attr, bad_cmd, idle);
    else n_pass++;
    #2;
    nrst = 1'b1;
    tick();
    wq.delete();
    send(8'h41);
    tick();
    n_checks++;
    if ({bad_cmd, idle, wq.size()} !== {1'b1, 1'b1, 32'd0})
      $display("FAIL mid_reset_resume: bad=%b idle=%b writes=%0d want 1 1 0", bad_cmd, idle, wq.size());
    else n_pass++;
  endtask

  task automatic test_write_256();
    int errs;
    logic [27:0] exp_w;
    wq.delete();
    send(8'h02); send(8'h00);
    for (int i = 0; i < 255; i++) send(8'(i));
    n_checks++;
    if (idle !== 1'b0) $display("FAIL n256_busy: idle=%b want 0 before last byte", idle);
    else n_pass++;
    send(8'hFF);
    tick();
    n_checks++;
    if (idle !== 1'b1 || wq.size() != 256)
      $display("FAIL n256_count: idle=%b writes=%0d want 1 256", idle, wq.size());
    else n_pass++;
    errs = 0;
    for (int i = 0; i < 256 && i < wq.size(); i++) begin
      exp_w = {12'(i), 8'h0F, 8'(i)};
      if (wq[i] !== exp_w) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL n256_contents: %0d wrong entries want 0", errs);
    else n_pass++;
  endtask

  task automatic test_sparse();
    logic [7:0] seq [8];
    seq = '{8'h01, 8'h10, 8'h00, 8'h02, 8'h03, 8'h41, 8'h42, 8'h43};
    apply_reset();
    wq.delete();
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    tick();
    n_checks++;
    if (wq.size() != 3 || wq[0] !== {12'h010, 16'h0F41} || wq[1] !== {12'h011, 16'h0F42} || wq[2] !== {12'h012, 16'h0F43})
      $display("FAIL sparse_writes: count=%0d w0=%h w1=%h w2=%h want 3 0100F41 0110F42 0120F43", wq.size(),
               (wq.size() > 0) ? wq[0] : 28'h0, (wq.size() > 1) ? wq[1] : 28'h0, (wq.size() > 2) ? wq[2] : 28'h0);
    else n_pass++;
    n_checks++;
    if ({idle, bad_cmd} !== 2'b10) $display("FAIL sparse_state: idle=%b bad=%b want 1 0", idle, bad_cmd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_set_attr();
    test_wrap_and_range();
    test_bad_opcode();
    test_reset_mid_cmd();
    test_write_256();
    test_sparse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
